data_pipe_fifo: RTL and testbench
=================================

// Module: data_pipe_fifo
// PURPOSE
//  Parametrised successor of the fixed 8-bit DATA_I->DATA_O datapath block.
//  Generalises width and buffering depth and adds a valid/ready handshake on both sides.
//  Sits between a producer and the core datapath; TEST_TOP-style benches instantiate it in place of TOP.
//  Output is first-word-fall-through and registered; the block provides an occupancy level.
// PARAMETERS
//  WIDTH  8  data word width in bits (>=1)
//  DEPTH  4  storage entries; power of two, >=2
//  AW     $clog2(DEPTH)  derived localparam, pointer width; not overridable
// PORTS
//  CLK_I    in   1           clock, rising edge
//  RST_I    in   1           reset, asynchronous, active-high
//  DATA_I   in   WIDTH       write data
//  VALID_I  in   1           write request
//  READY_O  out  1           space available (write accepted when VALID_I&READY_O)
//  DATA_O   out  WIDTH       head-of-queue data
//  VALID_O  out  1           DATA_O holds a valid word
//  READY_I  in   1           consumer accepts (read when VALID_O&READY_I)
//  LEVEL_O  out  AW+1        number of stored words, 0..DEPTH
//  CLR_I    in   1           synchronous flush (only with DATA_PIPE_CLR_EN)
// BEHAVIOUR
//  - Reset (RST_I=1, async): all pointers 0; LEVEL_O=0; VALID_O=0; READY_O=1; DATA_O=0.
//    Storage RAM is not reset. Release is sampled on the next CLK_I rising edge.
//  - push = VALID_I & READY_O; pop = VALID_O & READY_I; both are evaluated at the rising edge.
//  - Latency: a word pushed at edge N shows on DATA_O with VALID_O=1 after edge N (1 cycle) when the queue was empty.
//  - Ordering: strict FIFO; no word is lost or duplicated.
//  - LEVEL_O: +1 on push only, -1 on pop only, unchanged on push&pop; registered.
//  - READY_O = (LEVEL_O != DEPTH), registered.
//  - Full: READY_O=0, so pushes are refused even if a pop occurs the same cycle.
//    READY_O rises the cycle after the pop.
//  - Empty: VALID_O=0; DATA_O holds the last value popped (not X, not cleared).
//  - Simultaneous push & pop at LEVEL 1..DEPTH-1:
//    - the head advances;
//    - the new word is appended;
//    - LEVEL_O is unchanged.
//  - Simultaneous push & pop at LEVEL 1: the pushed word becomes the head on the next cycle with VALID_O=1 (no bubble).
//  - Pointers: AW bits wide, wrap modulo DEPTH; full/empty are decided by LEVEL_O, not by pointer compare.
//  - VALID_I or READY_I toggling without a handshake has no effect.
//  - DATA_O is stable while VALID_O=1 and READY_I=0.
//  - Mid-operation reset: the queue is emptied immediately and asynchronously; stored words are discarded; outputs take reset values.
//  - No combinational path from VALID_I/READY_I to any output.
// CONFIGURATION
//  DATA_PIPE_CLR_EN defined:
//    - CLR_I port present.
//    - CLR_I=1 at an edge: pointers and LEVEL_O go to 0 and VALID_O to 0 next cycle; READY_O=1.
//    - A push in the same cycle is discarded (CLR_I wins).
//  DATA_PIPE_CLR_EN undefined:
//    - CLR_I port absent.
//    - Flush only via RST_I.
// TESTING
//  1. RST_I=1 then 0; DATA_I=8'h01 with VALID_I for 1 cycle; READY_I=1
//     -> VALID_O=1, DATA_O=8'h01 one cycle later; LEVEL_O 1 then 0.
//  2. READY_I=0; push 8'h10..8'h13
//     -> LEVEL_O=4, READY_O=0; a 5th push of 8'h14 is refused.
//     Then READY_I=1 -> outputs 10,11,12,13 in order, LEVEL_O=0.
//  3. Continuous push & pop for 20 cycles, data 0..19, READY_I=1
//     -> LEVEL_O stays 1; output sequence 0..19 with no gaps.
//  4. Full queue; READY_I=1 and VALID_I=1 on the same edge
//     -> push refused, LEVEL_O=3; READY_O=1 next cycle.
//  5. LEVEL_O=3; assert RST_I asynchronously between edges
//     -> VALID_O=0, LEVEL_O=0, READY_O=1 before the next edge.
//     After release, push 8'hA5 -> DATA_O=8'hA5.
//  6. With DATA_PIPE_CLR_EN: LEVEL_O=2; CLR_I=1 with push of 8'h55
//     -> LEVEL_O=0, VALID_O=0 next cycle; 8'h55 never appears on DATA_O.

Source files
------------

// File: rtl/data_pipe_fifo.sv
// Parametrised first-word-fall-through FIFO with registered outputs, valid/ready on both sides and occupancy level.
// Optional synchronous flush input CLR_I is present only when DATA_PIPE_CLR_EN is defined.
module data_pipe_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic [WIDTH-1:0] DATA_I,
    input  logic             VALID_I,
    output logic             READY_O,
    output logic [WIDTH-1:0] DATA_O,
    output logic             VALID_O,
    input  logic             READY_I,
    output logic [AW:0]      LEVEL_O
`ifdef DATA_PIPE_CLR_EN
    ,
    input  logic             CLR_I
`endif
);

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0] LVL_ZERO = '0;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             r_valid;
    logic             r_ready;
    logic [WIDTH-1:0] r_data;

    logic             w_push;
    logic             w_pop;
    logic             w_clr;
    logic [AW:0]      w_level_next;
    logic [AW-1:0]    w_rd_ptr_inc;
    logic [WIDTH-1:0] w_head_next;

`ifdef DATA_PIPE_CLR_EN
    assign w_clr = CLR_I;
`else
    assign w_clr = 1'b0;
`endif

    // Handshakes only look at registered flags, so no input reaches an output combinationally.
    assign w_push       = VALID_I & r_ready;
    assign w_pop        = r_valid & READY_I;
    assign w_rd_ptr_inc = r_rd_ptr + AW'(1);

    always_comb begin
        w_level_next = r_level;
        if (w_clr)
            w_level_next = LVL_ZERO;
        else if (w_push && !w_pop)
            w_level_next = r_level + LVL_ONE;
        else if (w_pop && !w_push)
            w_level_next = r_level - LVL_ONE;
    end

    // The head register is a copy of mem[rd_ptr]; when the queue holds only the
    // head, the incoming word bypasses the RAM so there is no bubble.
    always_comb begin
        w_head_next = r_data;
        if (w_pop) begin
            if (r_level > LVL_ONE)
                w_head_next = r_mem[w_rd_ptr_inc];
            else if (w_push)
                w_head_next = DATA_I;
        end else if (w_push && r_level == LVL_ZERO) begin
            w_head_next = DATA_I;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (w_push)
            r_mem[r_wr_ptr] <= DATA_I;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_valid  <= 1'b0;
            r_ready  <= 1'b1;
            r_data   <= '0;
        end else begin
            r_level <= w_level_next;
            r_valid <= (w_level_next != LVL_ZERO);
            r_ready <= (w_level_next != LVL_FULL);
            if (w_clr) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)
                    r_rd_ptr <= w_rd_ptr_inc;
                r_data <= w_head_next;
            end
        end
    end

    assign READY_O = r_ready;
    assign VALID_O = r_valid;
    assign DATA_O  = r_data;
    assign LEVEL_O = r_level;

endmodule

// File: tb/tb_data_pipe_fifo.sv
// Self-checking bench for data_pipe_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_data_pipe_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       vin = 1'b0;
    logic       rin = 1'b0;
    logic       ready_o;
    logic       valid_o;
    logic [7:0] dout;
    logic [2:0] level;
`ifdef DATA_PIPE_CLR_EN
    logic       clr = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] q[$];
    logic [7:0] last_out = 8'h00;

    data_pipe_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .CLK_I   (clk),
        .RST_I   (rst),
        .DATA_I  (din),
        .VALID_I (vin),
        .READY_O (ready_o),
        .DATA_O  (dout),
        .VALID_O (valid_o),
        .READY_I (rin),
        .LEVEL_O (level)
`ifdef DATA_PIPE_CLR_EN
        ,
        .CLR_I   (clr)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model of the queue: a word is accepted whenever the queue is not full,
    // a word leaves whenever the queue is not empty and the consumer is ready.
    function automatic logic [7:0] exp_data();
        return (q.size() != 0) ? q[0] : last_out;
    endfunction

    task automatic step();
        bit         do_push;
        bit         do_pop;
        bit         do_clr;
        logic [7:0] d;
        do_clr = 1'b0;
`ifdef DATA_PIPE_CLR_EN
        do_clr = clr;
`endif
        do_push = vin && (q.size() != DEPTH);
        do_pop  = rin && (q.size() != 0);
        d = din;
        @(posedge clk);
        #1;
        if (do_clr) begin
            if (q.size() != 0) last_out = q[0];
            q.delete();
        end else begin
            if (do_pop) last_out = q.pop_front();
            if (do_push) q.push_back(d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; vin = 1'b0; rin = 1'b0;
        @(posedge clk); #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", dout); end
        rst = 1'b0;
        q.delete(); last_out = 8'h00;
        $display("test_reset done");
    endtask

    task automatic test_single();
        din = 8'h01; vin = 1'b1; rin = 1'b1;
        step();
        vin = 1'b0;
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", valid_o); end
        checks++; if (dout !== 8'h01) begin errors++; $display("FAIL single_data: got %h want 01", dout); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level1: got %0d want 1", level); end
        step();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_level0: got %0d want 0", level); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL single_empty_valid: got %b want 0", valid_o); end
        checks++; if (dout !== 8'h01) begin errors++; $display("FAIL single_hold_data: got %h want 01", dout); end
        $display("test_single done");
    endtask

    task automatic test_fill_drain();
        rin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din = 8'h10 + 8'(i); vin = 1'b1;
            step();
        end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level: got %0d want 4", level); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b want 0", ready_o); end
        din = 8'h14; vin = 1'b1;
        step();
        vin = 1'b0;
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_refused: level got %0d want 4", level); end
        checks++; if (dout !== 8'h10) begin errors++; $display("FAIL fill_stall_data: got %h want 10", dout); end
        rin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dout !== 8'h10 + 8'(i) || valid_o !== 1'b1) begin
                errors++; $display("FAIL drain_order[%0d]: got %h/%b want %h/1", i, dout, valid_o, 8'h10 + 8'(i));
            end
            step();
        end
        checks++; if (level !== 3'd0 || valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty: level %0d valid %b want 0/0", level, valid_o); end
        rin = 1'b0;
        $display("test_fill_drain done");
    endtask

    task automatic test_stream();
        rin = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din = 8'(i); vin = 1'b1;
            step();
            checks++;
            if (dout !== 8'(i) || level !== 3'd1 || valid_o !== 1'b1) begin
                errors++; $display("FAIL stream[%0d]: got data %h level %0d valid %b want %h/1/1", i, dout, level, valid_o, 8'(i));
            end
        end
        vin = 1'b0;
        step();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL stream_drain: level got %0d want 0", level); end
        rin = 1'b0;
        $display("test_stream done");
    endtask

    task automatic test_full_pushpop();
        rin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din = 8'($urandom_range(0, 255)); vin = 1'b1;
            step();
        end
        din = 8'hEE; vin = 1'b1; rin = 1'b1;
        step();
        vin = 1'b0; rin = 1'b0;
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL full_pushpop_level: got %0d want 3", level); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL full_pushpop_ready: got %b want 1", ready_o); end
        checks++; if (dout !== exp_data()) begin errors++; $display("FAIL full_pushpop_head: got %h want %h", dout, exp_data()); end
        rin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (dout !== exp_data()) begin errors++; $display("FAIL full_pushpop_drain[%0d]: got %h want %h", i, dout, exp_data()); end
            step();
        end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL full_pushpop_empty: level %0d want 0 (0xEE must not be stored)", level); end
        rin = 1'b0;
        $display("test_full_pushpop done");
    endtask

    task automatic test_async_reset();
        rin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din = 8'($urandom_range(0, 255)); vin = 1'b1;
            step();
        end
        vin = 1'b0;
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL areset_pre_level: got %0d want 3", level); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (valid_o !== 1'b0 || level !== 3'd0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL areset_immediate: valid %b level %0d ready %b want 0/0/1", valid_o, level, ready_o);
        end
        q.delete(); last_out = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        din = 8'hA5; vin = 1'b1;
        step();
        vin = 1'b0;
        checks++; if (dout !== 8'hA5 || valid_o !== 1'b1 || level !== 3'd1) begin
            errors++; $display("FAIL areset_after: data %h valid %b level %0d want a5/1/1", dout, valid_o, level);
        end
        rin = 1'b1;
        step();
        rin = 1'b0;
        $display("test_async_reset done");
    endtask

`ifdef DATA_PIPE_CLR_EN
    task automatic test_clr();
        rin = 1'b0;
        for (int i = 0; i < 2; i++) begin
            din = 8'h30 + 8'(i); vin = 1'b1;
            step();
        end
        din = 8'h55; vin = 1'b1; clr = 1'b1;
        step();
        clr = 1'b0; vin = 1'b0;
        checks++; if (level !== 3'd0 || valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL clr_state: level %0d valid %b ready %b want 0/0/1", level, valid_o, ready_o);
        end
        rin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (dout === 8'h55 || valid_o !== 1'b0) begin errors++; $display("FAIL clr_discard[%0d]: data %h valid %b", i, dout, valid_o); end
        end
        rin = 1'b0;
        $display("test_clr done");
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            din = 8'($urandom_range(0, 255));
            vin = ($urandom_range(0, 3) != 0);
            rin = ($urandom_range(0, 2) != 0);
            if (i >= 150 && i < 250) rin = ($urandom_range(0, 4) == 0);
            step();
            checks++;
            if (dout !== exp_data() || valid_o !== (q.size() != 0) ||
                level !== 3'(q.size()) || ready_o !== (q.size() != DEPTH)) begin
                errors++;
                $display("FAIL random[%0d]: got data %h valid %b level %0d ready %b want %h/%b/%0d/%b",
                         i, dout, valid_o, level, ready_o, exp_data(), q.size() != 0, q.size(), q.size() != DEPTH);
            end
        end
        vin = 1'b0; rin = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_stream();
        test_full_pushpop();
        test_async_reset();
`ifdef DATA_PIPE_CLR_EN
        test_clr();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
